awgn: RTL and testbench

- Additive white Gaussian noise channel model for complex baseband samples.
- Each enabled cycle it adds an independent, approximately Gaussian noise sample to the real and imaginary 16-bit inputs and emits the saturated noisy result.
- Noise comes from a central-limit sum of LFSR uniform variates.
- Sits between modulator and demodulator in the link-simulation chain; also exports the real-channel raw noise sample for statistics checks.

---
 rtl/awgn.sv | 141 ++++++++++++++
 tb/tb_awgn.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/awgn.sv
// ---------------------------------------------------------------------------
// awgn -- additive white Gaussian noise channel model for complex baseband.
//
// Every cycle with read=1 an independent, approximately Gaussian noise sample
// is formed per channel (central-limit sum of four 10-bit LFSR uniforms) and
// added to the input sample.  The saturated sum appears two cycles later.
//
// Ports:
//   clk                    system clock, rising edge
//   reset                  asynchronous, active-low reset
//   read                   input valid / enable; LFSRs advance only when high
//   X_in_real, X_in_imag   signed BI-bit input sample
//   busy                   output valid
//   Y_out_real, Y_out_imag signed BI-bit saturated noisy output
//   sum_real_n_truncation  signed 12-bit real noise used for Y_out_real
// ---------------------------------------------------------------------------
module awgn #(
    parameter int BI          = 16,
    parameter int NOISE_SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read,
    input  logic signed [BI-1:0] X_in_real,
    input  logic signed [BI-1:0] X_in_imag,
    output logic                 busy,
    output logic signed [BI-1:0] Y_out_real,
    output logic signed [BI-1:0] Y_out_imag,
    output logic signed [11:0]   sum_real_n_truncation
);

    // Sum width: two guard bits above the sample width.
    localparam int SW = BI + 2;

    localparam logic signed [BI-1:0] SAT_MAX = {1'b0, {(BI-1){1'b1}}};
    localparam logic signed [BI-1:0] SAT_MIN = {1'b1, {(BI-1){1'b0}}};
    localparam logic signed [SW-1:0] SUM_MAX = SW'(SAT_MAX);
    localparam logic signed [SW-1:0] SUM_MIN = SW'(SAT_MIN);

    // Entries 0..3 feed the real channel, 4..7 the imaginary channel.
    localparam logic [15:0] SEED [8] = '{
        16'hACE1, 16'h1D2B, 16'h7E35, 16'h5A5A,
        16'hE2D7, 16'h9135, 16'h4C6B, 16'h2F8E
    };

    logic [15:0]          lfsr_q [8];
    logic [15:0]          lfsr_d [8];
    logic signed [11:0]   n_re_d, n_im_d;
    logic signed [11:0]   n_re_q, n_im_q;
    logic signed [BI-1:0] x_re_q, x_im_q;
    logic                 valid1_q;
    logic signed [BI-1:0] y_re_d, y_im_d;

    // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    // Summing the raw uniforms and removing 4*512 once is the same as summing
    // the four centred values; bits [12:1] are the arithmetic >>>1 result.
    function automatic logic signed [11:0] clt_noise(
        input logic [9:0] a,
        input logic [9:0] b,
        input logic [9:0] c,
        input logic [9:0] d
    );
        logic [12:0] u_sum;
        logic [12:0] s;
        u_sum = {3'b000, a} + {3'b000, b} + {3'b000, c} + {3'b000, d};
        s     = u_sum - 13'd2048;
        return $signed(s[12:1]);
    endfunction

    function automatic logic signed [BI-1:0] add_sat(
        input logic signed [BI-1:0] x,
        input logic signed [11:0]   n
    );
        logic signed [SW-1:0] sum;
        sum = SW'(x) + (SW'(n) <<< NOISE_SHIFT);
        if (sum > SUM_MAX)      return SAT_MAX;
        else if (sum < SUM_MIN) return SAT_MIN;
        else                    return sum[BI-1:0];
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            lfsr_d[i] = lfsr_step(lfsr_q[i]);
        end
        n_re_d = clt_noise(lfsr_q[0][9:0], lfsr_q[1][9:0],
                           lfsr_q[2][9:0], lfsr_q[3][9:0]);
        n_im_d = clt_noise(lfsr_q[4][9:0], lfsr_q[5][9:0],
                           lfsr_q[6][9:0], lfsr_q[7][9:0]);
        y_re_d = add_sat(x_re_q, n_re_q);
        y_im_d = add_sat(x_im_q, n_im_q);
    end

    // Stage 1: capture input and noise, advance the generators.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 8; i++) begin
                lfsr_q[i] <= SEED[i];
            end
            x_re_q   <= '0;
            x_im_q   <= '0;
            n_re_q   <= '0;
            n_im_q   <= '0;
            valid1_q <= 1'b0;
        end else begin
            valid1_q <= read;
            if (read) begin
                for (int unsigned i = 0; i < 8; i++) begin
                    lfsr_q[i] <= lfsr_d[i];
                end
                x_re_q <= X_in_real;
                x_im_q <= X_in_imag;
                n_re_q <= n_re_d;
                n_im_q <= n_im_d;
            end
        end
    end

    // Stage 2: saturated addition; outputs hold across gaps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy                  <= 1'b0;
            Y_out_real            <= '0;
            Y_out_imag            <= '0;
            sum_real_n_truncation <= '0;
        end else begin
            busy <= valid1_q;
            if (valid1_q) begin
                Y_out_real            <= y_re_d;
                Y_out_imag            <= y_im_d;
                sum_real_n_truncation <= n_re_q;
            end
        end
    end

endmodule

// File: tb/tb_awgn.sv
module tb_awgn;

    localparam int NS = 0;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               read = 1'b0;
    logic signed [15:0] X_in_real = '0;
    logic signed [15:0] X_in_imag = '0;
    logic               busy;
    logic signed [15:0] Y_out_real;
    logic signed [15:0] Y_out_imag;
    logic signed [11:0] sum_real_n_truncation;

    awgn #(.BI(16), .NOISE_SHIFT(NS)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .read                  (read),
        .X_in_real             (X_in_real),
        .X_in_imag             (X_in_imag),
        .busy                  (busy),
        .Y_out_real            (Y_out_real),
        .Y_out_imag            (Y_out_imag),
        .sum_real_n_truncation (sum_real_n_truncation)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] mr [4];
    logic [15:0] mi [4];
    int m_v1, m_xr, m_xi, m_nr, m_ni;
    int e_busy, e_yr, e_yi, e_sum;

    // Taps at bit positions 0,2,3,5 expressed as a mask (0x002D).
    function automatic logic [15:0] m_step(input logic [15:0] s);
        logic [15:0] t;
        t = s & 16'h002D;
        return {^t, s[15:1]};
    endfunction

    function automatic int m_noise(input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] c, input logic [15:0] d);
        int s;
        s = (int'(a[9:0]) - 512) + (int'(b[9:0]) - 512)
          + (int'(c[9:0]) - 512) + (int'(d[9:0]) - 512);
        return s >>> 1;
    endfunction

    function automatic int m_sat(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        mr[0] = 16'hACE1; mr[1] = 16'h1D2B; mr[2] = 16'h7E35; mr[3] = 16'h5A5A;
        mi[0] = 16'hE2D7; mi[1] = 16'h9135; mi[2] = 16'h4C6B; mi[3] = 16'h2F8E;
        m_v1 = 0; m_xr = 0; m_xi = 0; m_nr = 0; m_ni = 0;
        e_busy = 0; e_yr = 0; e_yi = 0; e_sum = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), e_busy);
        chk({tag, "_yre"},  int'(Y_out_real), e_yr);
        chk({tag, "_yim"},  int'(Y_out_imag), e_yi);
        chk({tag, "_nre"},  int'(sum_real_n_truncation), e_sum);
    endtask

    // One clock: drive, advance the model across the edge, check #1 after.
    task automatic drive(input bit rd, input int xr, input int xi, input string tag);
        read      = rd;
        X_in_real = 16'(xr);
        X_in_imag = 16'(xi);
        @(posedge clk);
        if (m_v1 != 0) begin
            e_busy = 1;
            e_yr   = m_sat(m_xr + m_nr * (1 << NS));
            e_yi   = m_sat(m_xi + m_ni * (1 << NS));
            e_sum  = m_nr;
        end else begin
            e_busy = 0;
        end
        if (rd) begin
            m_v1 = 1; m_xr = xr; m_xi = xi;
            m_nr = m_noise(mr[0], mr[1], mr[2], mr[3]);
            m_ni = m_noise(mi[0], mi[1], mi[2], mi[3]);
            for (int i = 0; i < 4; i++) begin
                mr[i] = m_step(mr[i]);
                mi[i] = m_step(mi[i]);
            end
        end else begin
            m_v1 = 0;
        end
        #1;
        check_outputs(tag);
    endtask

    // Reset pulse asserted between edges; outputs must clear without a clock.
    task automatic async_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        read = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    int xr_tab [8] = '{32767, -32768, 32000, -32000, 1, -1, 0, 12345};
    int xi_tab [8] = '{-32768, 32767, -31900, 31900, -1, 1, 0, -12345};

    initial begin
        model_reset();

        // Held reset: all outputs zero.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_yre",  int'(Y_out_real), 0);
        chk("rst_yim",  int'(Y_out_imag), 0);
        chk("rst_nre",  int'(sum_real_n_truncation), 0);
        reset = 1'b1;

        // First sample from the seeds: n_real = -357>>>1 = -179, n_imag = 5>>>1 = 2.
        drive(1'b1, 1000, -2000, "lat_k1");
        chk("lat_busy_k1", int'(busy), 0);
        drive(1'b0, 0, 0, "lat_k2");
        chk("first_busy", int'(busy), 1);
        chk("first_yre",  int'(Y_out_real), 821);
        chk("first_yim",  int'(Y_out_imag), -1998);
        chk("first_nre",  int'(sum_real_n_truncation), -179);
        drive(1'b0, 0, 0, "gap_hold");
        chk("gap_busy",   int'(busy), 0);
        chk("gap_yre",    int'(Y_out_real), 821);

        // Zero input with a periodic read gap pattern.
        for (int i = 0; i < 200; i++) begin
            drive((i % 7) != 3, 0, 0, "zero");
            chk("zero_range", int'((sum_real_n_truncation >= -12'sd1024) &&
                                   (sum_real_n_truncation <= 12'sd1022)), 1);
        end

        // Saturation at the rails, continuous read.
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 32767, -32768, "sat");
            if (i > 1) begin
                chk("sat_re_nowrap", int'(Y_out_real[15]), 0);
                chk("sat_im_nowrap", int'(Y_out_imag[15]), 1);
            end
        end

        // Mid-stream asynchronous reset, then boundary table.
        async_reset("arst1");
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, xr_tab[i % 8], xi_tab[i % 8], "tab");
        end
        drive(1'b0, 0, 0, "tab_drain1");
        drive(1'b0, 0, 0, "tab_drain2");

        // Reproducibility: same stimulus after reset follows the seeded sequence again.
        for (int pass = 0; pass < 2; pass++) begin
            async_reset("arst_rep");
            for (int i = 0; i < 100; i++) begin
                drive(1'b1, (i * 37) - 1800, 900 - (i * 23), "rep");
            end
        end
        drive(1'b0, 0, 0, "end1");
        drive(1'b0, 0, 0, "end2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
